// File: rtl/neuron_train_unit.sv
// Single ReLU neuron (Q8.8) with its forward/backward phase controller.
// Training runs EPOCHS SGD iterations; validation runs one forward pass with the stored weights.
module neuron_train_unit #(
  parameter int N        = 6,
  parameter int BITS     = 16,
  parameter int FRAC     = 8,
  parameter int EPOCHS   = 12,
  parameter int LR_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tr,
  input  logic              vl,
  input  logic [N*BITS-1:0] x,
  input  logic [N*BITS-1:0] w,
  input  logic [BITS-1:0]   b,
  input  logic [BITS-1:0]   dz_in,
  input  logic [BITS-1:0]   w_in,
  output logic [BITS-1:0]   y,
  output logic              fph,
  output logic              fpo,
  output logic              bph,
  output logic              bpo,
  output logic              busy
);

  localparam int PROD_W = 2 * BITS;
  localparam int ACC_W  = PROD_W + $clog2(N) + 1;
  localparam int EP_W   = $clog2(EPOCHS + 1);

  typedef enum logic [2:0] {IDLE, T_FPH, T_FPO, T_BPO, T_BPH, V_FPH, V_FPO} state_t;

  state_t                 state, ns;
  logic [EP_W-1:0]        epoch;
  logic signed [BITS-1:0] wt [N];
  logic signed [BITS-1:0] bias, z, dz;

  logic signed [BITS-1:0]   xv [N];
  logic signed [PROD_W-1:0] prod [N];
  logic signed [ACC_W-1:0]  acc;
  logic signed [BITS-1:0]   z_nxt, g_nxt, b_nxt;
  logic signed [BITS-1:0]   w_nxt [N];
  logic signed [PROD_W-1:0] gprod, uprod;
  logic signed [BITS-1:0]   dzi, wi;

  assign dzi = dz_in;
  assign wi  = w_in;

  function automatic logic signed [ACC_W-1:0] ext_w(input logic signed [BITS-1:0] v);
    return {{(ACC_W-BITS){v[BITS-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_p(input logic signed [PROD_W-1:0] v);
    return {{(ACC_W-PROD_W){v[PROD_W-1]}}, v};
  endfunction

  function automatic logic signed [BITS-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi, lo;
    hi = {{(ACC_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    lo = {{(ACC_W-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
    if (v > hi)      return hi[BITS-1:0];
    else if (v < lo) return lo[BITS-1:0];
    else             return v[BITS-1:0];
  endfunction

  // {busy, fph, fpo, bpo, bph} for the state about to be entered
  function automatic logic [4:0] decode(input state_t s);
    case (s)
      T_FPH, V_FPH: return 5'b11000;
      T_FPO, V_FPO: return 5'b10100;
      T_BPO:        return 5'b10010;
      T_BPH:        return 5'b10001;
      default:      return 5'b00000;
    endcase
  endfunction

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      xv[i]   = x[i*BITS +: BITS];
      prod[i] = xv[i] * wt[i];
      acc     = acc + ext_p(prod[i]);
    end
    z_nxt = sat((acc >>> FRAC) + ext_w(bias));
    gprod = dzi * wi;
    g_nxt = sat(ext_p(gprod) >>> FRAC);
    uprod = '0;
    for (int i = 0; i < N; i++) begin
      uprod    = dz * xv[i];
      w_nxt[i] = sat(ext_w(wt[i]) - ((ext_p(uprod) >>> FRAC) >>> LR_SHIFT));
    end
    b_nxt = sat(ext_w(bias) - (ext_w(dz) >>> LR_SHIFT));
  end

  always_comb begin
    ns = IDLE;
    case (state)
      IDLE:    ns = tr ? T_FPH : (vl ? V_FPH : IDLE);
      T_FPH:   ns = T_FPO;
      T_FPO:   ns = T_BPO;
      T_BPO:   ns = T_BPH;
      T_BPH:   ns = (epoch == EP_W'(EPOCHS - 1)) ? IDLE : T_FPH;
      V_FPH:   ns = V_FPO;
      default: ns = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      epoch <= '0;
      {busy, fph, fpo, bpo, bph} <= '0;
      y    <= '0;
      z    <= '0;
      dz   <= '0;
      bias <= '0;
      for (int i = 0; i < N; i++) wt[i] <= '0;
    end else begin
      state <= ns;
      {busy, fph, fpo, bpo, bph} <= decode(ns);
      case (state)
        IDLE: begin
          if (tr) begin
            epoch <= '0;
            bias  <= b;
            for (int i = 0; i < N; i++) wt[i] <= w[i*BITS +: BITS];
          end
        end
        T_FPH, V_FPH: begin
          z <= z_nxt;
          y <= (z_nxt > 0) ? z_nxt : '0;
        end
        // ReLU derivative is taken as 0 at z == 0
        T_BPO: dz <= (z > 0) ? g_nxt : '0;
        T_BPH: begin
          epoch <= epoch + 1'b1;
          bias  <= b_nxt;
          for (int i = 0; i < N; i++) wt[i] <= w_nxt[i];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_train_unit.sv
// Scoreboard bench for neuron_train_unit: expected y values are queued at stimulus
// time and checked by a monitor whenever an fpo strobe presents y.
module tb_neuron_train_unit;

  localparam int N    = 6;
  localparam int BITS = 16;

  logic              clk = 1'b0;
  logic              rst_n, tr, vl;
  logic [N*BITS-1:0] x, w;
  logic [BITS-1:0]   b, dz_in, w_in, y;
  logic              fph, fpo, bph, bpo, busy;

  int          nvec = 0;
  int          nmis = 0;
  logic [15:0] sbq [$];

  neuron_train_unit dut (
    .clk(clk), .rst_n(rst_n), .tr(tr), .vl(vl), .x(x), .w(w), .b(b),
    .dz_in(dz_in), .w_in(w_in), .y(y), .fph(fph), .fpo(fpo), .bph(bph),
    .bpo(bpo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every fpo cycle presents a y value that must match the next queued entry
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (fpo === 1'b1) begin
        if (sbq.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL sb_unexpected: got y=%h with empty queue at %0t", y, $time);
        end else begin
          e = sbq.pop_front();
          chk("y_fpo", {16'h0, y}, {16'h0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic set_all(input logic [15:0] xv, input logic [15:0] wv);
    for (int i = 0; i < N; i++) begin
      x[i*BITS +: BITS] = xv;
      w[i*BITS +: BITS] = wv;
    end
    b = 16'h0000;
  endtask

  // Returns just after the edge that samples the request
  task automatic start(input logic t, input logic v);
    @(posedge clk);
    #1 tr = t; vl = v;
    @(posedge clk);
    #1 tr = 1'b0; vl = 1'b0;
  endtask

  function automatic logic [4:0] pat(input int c);
    case (c % 4)
      0:       return 5'b11000;
      1:       return 5'b10100;
      2:       return 5'b10010;
      default: return 5'b10001;
    endcase
  endfunction

  initial begin
    rst_n = 1'b1; tr = 1'b0; vl = 1'b0;
    dz_in = 16'h0100; w_in = 16'h0080;
    set_all(16'h0100, 16'h0100);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {27'h0, busy, fph, fpo, bpo, bph}, 32'h0);
    chk("reset_y", {16'h0, y}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Positive training: y drops by 6*8+8 = 0x38 per epoch; vl is raised mid-run and ignored
    for (int k = 0; k < 12; k++) sbq.push_back(16'h0600 - 16'(56 * k));
    start(1'b1, 1'b0);
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      chk("strobe_seq", {27'h0, busy, fph, fpo, bpo, bph}, {27'h0, pat(c)});
      if (c == 10) vl = 1'b1;
      if (c == 20) vl = 1'b0;
    end
    @(negedge clk);
    chk("idle_after_train", {27'h0, busy, fph, fpo, bpo, bph}, 32'h0);
    sbq.push_back(16'h0360);
    start(1'b0, 1'b1);
    @(negedge clk);
    chk("v_fph", {27'h0, busy, fph, fpo, bpo, bph}, 32'h18);
    repeat (3) @(posedge clk);
    #1 chk("idle_after_val", {31'h0, busy}, 32'h0);

    // Negative pre-activation: z = 0xF9B9, ReLU keeps y at 0 and dZ at 0
    x = {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0201, 16'hFEEF};
    w = {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFD00, 16'h0400};
    b = 16'h0000;
    for (int k = 0; k < 12; k++) sbq.push_back(16'h0000);
    start(1'b1, 1'b0);
    repeat (48) @(posedge clk);
    sbq.push_back(16'h0000);
    start(1'b0, 1'b1);
    repeat (3) @(posedge clk);

    // tr and vl together: training wins; large inputs saturate y
    set_all(16'h7F00, 16'h7F00);
    for (int k = 0; k < 12; k++) sbq.push_back(16'h7FFF);
    start(1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("prio_seq", {27'h0, busy, fph, fpo, bpo, bph}, {27'h0, pat(c)});
    end
    repeat (46) @(posedge clk);
    #1 chk("idle_after_sat", {31'h0, busy}, 32'h0);

    // Asynchronous reset during T_BPO aborts the run and clears the weights
    set_all(16'h0100, 16'h0100);
    sbq.push_back(16'h0600);
    start(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_reset_bpo", {27'h0, busy, fph, fpo, bpo, bph}, 32'h12);
    chk("pre_reset_y", {16'h0, y}, 32'h0600);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {27'h0, busy, fph, fpo, bpo, bph}, 32'h0);
    chk("async_reset_y", {16'h0, y}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {31'h0, busy}, 32'h0);
    sbq.push_back(16'h0000);
    start(1'b0, 1'b1);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
    chk("sb_drain", sbq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
